// File: rtl/poly_tone_synth.sv
// rtl/poly_tone_synth.sv - polyphonic square-wave tone synthesizer with per-voice envelopes and PWM output
// Each voice runs a half-period counter and a linear attack/release envelope; voices are summed into a PWM stream.
module poly_tone_synth #(
   parameter int NUM_VOICES = 4,
   parameter int AMP_W      = 4,
   parameter int PWM_W      = 8,
   parameter int ENV_DIV    = 100000
) (
   input  logic                    clk_100M,
   input  logic                    rst_n,
   input  logic [3*NUM_VOICES-1:0] note,
   input  logic [3*NUM_VOICES-1:0] octave,
   output logic                    AIN,
   output logic                    GAIN,
   output logic                    NC,
   output logic                    ACTIVE,
   output logic [NUM_VOICES-1:0]   voice_active
);

   localparam int SUM_W = AMP_W + $clog2(NUM_VOICES);
   localparam int PRE_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
   localparam logic [AMP_W-1:0] AMP_MAX = '1;
   localparam logic [PWM_W-1:0] PWM_MAX = '1;

   generate
      if (PWM_W < SUM_W || NUM_VOICES < 1 || NUM_VOICES > 8 || ENV_DIV < 1) begin : g_bad_params
         $error("poly_tone_synth: illegal parameter combination");
      end
   endgenerate

   function automatic logic [31:0] base_period(input logic [2:0] n);
      case (n)
         3'd1:    base_period = 32'd3057805;
         3'd2:    base_period = 32'd2724194;
         3'd3:    base_period = 32'd2426982;
         3'd4:    base_period = 32'd2290765;
         3'd5:    base_period = 32'd2040840;
         3'd6:    base_period = 32'd1818182;
         3'd7:    base_period = 32'd1619816;
         default: base_period = 32'd0;
      endcase
   endfunction

   assign GAIN = 1'b1;
   assign NC   = 1'b0;

   logic [PRE_W-1:0] presc;
   logic             env_tick;

   assign env_tick = (presc == PRE_W'(ENV_DIV - 1));

   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (env_tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PRE_W'(1);
      end
   end

   logic [NUM_VOICES*AMP_W-1:0] amp_flat;
   logic [NUM_VOICES-1:0]       sq_vec;
   logic [NUM_VOICES-1:0]       va_next;

   generate
      for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
         logic [2:0]       n;
         logic [2:0]       o;
         logic             gate;
         logic [31:0]      tgt;
         logic [31:0]      cnt;
         logic [31:0]      per;
         logic             sq;
         logic [AMP_W-1:0] amp;
         logic [AMP_W-1:0] amp_nx;

         assign n    = note[3*i +: 3];
         assign o    = octave[3*i +: 3];
         assign gate = (n != 3'd0);
         assign tgt  = base_period(n) >> o;

         always_comb begin
            amp_nx = amp;
            if (env_tick) begin
               if (gate && amp != AMP_MAX) begin
                  amp_nx = amp + AMP_W'(1);
               end else if (!gate && amp != '0) begin
                  amp_nx = amp - AMP_W'(1);
               end
            end
         end

         // Period reloads only at a half-period boundary, so retuning never shortens a pulse.
         always_ff @(posedge clk_100M or negedge rst_n) begin
            if (!rst_n) begin
               cnt <= 32'd1;
               per <= 32'hFFFF_FFFF;
               sq  <= 1'b0;
               amp <= '0;
            end else begin
               amp <= amp_nx;
               if (amp == '0 && !gate) begin
                  cnt <= 32'd1;
                  sq  <= 1'b0;
                  per <= tgt;
               end else if (cnt >= per) begin
                  sq  <= ~sq;
                  cnt <= 32'd1;
                  if (gate) begin
                     per <= tgt;
                  end
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
         end

         assign amp_flat[i*AMP_W +: AMP_W] = amp;
         assign sq_vec[i]                  = sq;
         assign va_next[i]                 = (amp_nx != '0);
      end
   endgenerate

   logic [SUM_W-1:0] sum;
   logic [PWM_W-1:0] duty;

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (sq_vec[i]) begin
            sum = sum + SUM_W'(amp_flat[i*AMP_W +: AMP_W]);
         end
      end
   end

   assign duty = PWM_W'(sum) << (PWM_W - SUM_W);

   logic [PWM_W-1:0] pwm_cnt;
   logic [PWM_W-1:0] duty_q;

   // Duty is latched only at the period wrap so a PWM period is never split.
   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt      <= '0;
         duty_q       <= '0;
         AIN          <= 1'b0;
         ACTIVE       <= 1'b0;
         voice_active <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
         if (pwm_cnt == PWM_MAX) begin
            duty_q <= duty;
         end
         AIN          <= (pwm_cnt < duty_q);
         voice_active <= va_next;
         ACTIVE       <= |va_next;
      end
   end

endmodule

// File: tb/tb_poly_tone_synth.sv
// tb/tb_poly_tone_synth.sv - self-checking bench for poly_tone_synth
// A timestamp-based reference model predicts every output each cycle; directed scenarios add literal checks.
module tb_poly_tone_synth;

   localparam int NV = 2;
   localparam int AW = 2;
   localparam int PW = 4;
   localparam int ED = 4;

   logic          clk_100M = 1'b0;
   logic          rst_n    = 1'b0;
   logic [3*NV-1:0] note   = '0;
   logic [3*NV-1:0] octave = '0;
   logic          AIN;
   logic          GAIN;
   logic          NC;
   logic          ACTIVE;
   logic [NV-1:0] voice_active;

   poly_tone_synth #(
      .NUM_VOICES(NV),
      .AMP_W(AW),
      .PWM_W(PW),
      .ENV_DIV(ED)
   ) dut (
      .clk_100M(clk_100M),
      .rst_n(rst_n),
      .note(note),
      .octave(octave),
      .AIN(AIN),
      .GAIN(GAIN),
      .NC(NC),
      .ACTIVE(ACTIVE),
      .voice_active(voice_active)
   );

   always #5 clk_100M = ~clk_100M;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: the oscillator is tracked as the absolute cycle of its next toggle.
   longint BASE [8] = '{0, 3057805, 2724194, 2426982, 2290765, 2040840, 1818182, 1619816};
   localparam int AMAX = (1 << AW) - 1;
   localparam int PMOD = 1 << PW;
   localparam int DSHIFT = PW - (AW + $clog2(NV));

   longint k;
   int     m_amp  [NV];
   bit     m_sq   [NV];
   longint m_per  [NV];
   longint m_next [NV];
   int     m_duty_q;
   bit     m_ain;
   bit     m_active;
   logic [NV-1:0] m_va;
   longint tog0 [$];
   int     amp0_seq [$];

   always @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         k = 0;
         for (int v = 0; v < NV; v++) begin
            m_amp[v]  = 0;
            m_sq[v]   = 0;
            m_per[v]  = 64'hFFFF_FFFF;
            m_next[v] = 64'hFFFF_FFFE;
         end
         m_duty_q = 0;
         m_ain    = 0;
         m_active = 0;
         m_va     = '0;
      end else begin
         int     sum;
         int     na [NV];
         bit     tick;
         bit     gate;
         int     n;
         int     o;
         longint tgt;
         tick = ((k % ED) == ED - 1);
         sum  = 0;
         for (int v = 0; v < NV; v++) sum += m_sq[v] ? m_amp[v] : 0;
         for (int v = 0; v < NV; v++) begin
            n    = int'(note[3*v +: 3]);
            o    = int'(octave[3*v +: 3]);
            gate = (n != 0);
            tgt  = BASE[n] >> o;
            na[v] = m_amp[v];
            if (tick && gate && m_amp[v] < AMAX) na[v] = m_amp[v] + 1;
            if (tick && !gate && m_amp[v] > 0) na[v] = m_amp[v] - 1;
            if (m_amp[v] == 0 && !gate) begin
               m_sq[v]   = 0;
               m_next[v] = k + 1;
            end else if (k >= m_next[v]) begin
               m_sq[v] = !m_sq[v];
               if (gate) m_per[v] = tgt;
               m_next[v] = k + ((m_per[v] < 1) ? 1 : m_per[v]);
               if (v == 0) tog0.push_back(k);
            end
         end
         m_ain = ((k % PMOD) < m_duty_q);
         if ((k % PMOD) == PMOD - 1) m_duty_q = sum << DSHIFT;
         if (na[0] != m_amp[0]) amp0_seq.push_back(na[0]);
         for (int v = 0; v < NV; v++) begin
            m_amp[v] = na[v];
            m_va[v]  = (na[v] != 0);
         end
         m_active = |m_va;
         k++;
      end
   end

   bit chk_en = 0;

   always @(negedge clk_100M) begin
      if (rst_n && chk_en) begin
         check("outputs{AIN,ACTIVE,va,GAIN,NC}",
               {AIN, ACTIVE, voice_active, GAIN, NC},
               {m_ain, m_active, m_va, 1'b1, 1'b0});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_100M);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_AIN"}, AIN, 0);
      check({tag, "_ACTIVE"}, ACTIVE, 0);
      check({tag, "_va"}, voice_active, 0);
      check({tag, "_GAIN"}, GAIN, 1);
      check({tag, "_NC"}, NC, 0);
   endtask

   task automatic wait_active(input bit level, input int bound, input string name);
      int i;
      for (i = 0; i < bound && ACTIVE !== level; i++) cyc(1);
      check(name, ACTIVE, level);
   endtask

   task automatic align_pwm_wrap();
      for (int i = 0; i < PMOD && (k % PMOD) != 0; i++) cyc(1);
   endtask

   task automatic count_ain(output int hi);
      hi = 0;
      for (int i = 0; i < PMOD; i++) begin
         cyc(1);
         if (AIN === 1'b1) hi++;
      end
   endtask

   initial begin
      longint press_k;
      int     hi;
      int     i;

      // Reset held with a key down.
      note   = 6'o06;
      octave = 6'o07;
      cyc(3);
      check_reset_outputs("reset_hold");
      note = '0;
      cyc(1);
      rst_n  = 1'b1;
      chk_en = 1;
      cyc(2);

      // Single voice pitch, attack and glitch-free retune.
      tog0.delete();
      note    = 6'o06;
      octave  = 6'o07;
      press_k = k;
      wait_active(1, 16, "attack_active");
      cyc(12);
      check("amp0_after_3_ticks", m_amp[0], 3);
      check("va_single", voice_active, 2'b01);
      check("first_toggle_at_press", (tog0.size() > 0) ? tog0[0] : -1, press_k);
      for (i = 0; i < 8000 && (k - press_k) < 7000; i++) cyc(1);
      octave = 6'o06;
      for (i = 0; i < 50000 && tog0.size() < 3; i++) cyc(1);
      check("toggle_count", tog0.size(), 3);
      if (tog0.size() >= 3) begin
         check("half_period_oct7", tog0[1] - tog0[0], 14204);
         check("half_period_oct6", tog0[2] - tog0[1], 28409);
      end

      // Release from amp 3.
      amp0_seq.delete();
      note = '0;
      wait_active(0, 20, "release_active_drop");
      check("release_steps", amp0_seq.size(), 3);
      if (amp0_seq.size() == 3) begin
         check("release_amp_a", amp0_seq[0], 2);
         check("release_amp_b", amp0_seq[1], 1);
         check("release_amp_c", amp0_seq[2], 0);
      end
      cyc(4);

      // Mix: both voices high, then only voice 1 high.
      note   = {3'd6, 3'd6};
      octave = {3'd6, 3'd7};
      cyc(20);
      align_pwm_wrap();
      check("duty_both_high", m_duty_q, 12);
      count_ain(hi);
      check("ain_high_both", hi, 12);
      for (i = 0; i < 20000 && !(m_sq[0] == 0 && m_sq[1] == 1); i++) cyc(1);
      cyc(20);
      align_pwm_wrap();
      check("duty_one_high", m_duty_q, 6);
      count_ain(hi);
      check("ain_high_one", hi, 6);

      // Saturation over 20 ticks, then gate drop on a tick cycle.
      cyc(20 * ED);
      check("sat_amp0", m_amp[0], 3);
      check("sat_amp1", m_amp[1], 3);
      check("sat_va", voice_active, 2'b11);
      for (i = 0; i < ED && (k % ED) != ED - 1; i++) cyc(1);
      note = '0;
      cyc(1);
      check("drop_on_tick_amp0", m_amp[0], 2);
      check("drop_on_tick_va", voice_active, 2'b11);
      wait_active(0, 16, "drop_active_fall");
      cyc(4);

      // Asynchronous reset mid-note; held key restarts attack.
      note   = 6'o05;
      octave = 6'o07;
      cyc(20);
      check("pre_reset_active", ACTIVE, 1);
      #2;
      chk_en = 0;
      rst_n  = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      cyc(3);
      rst_n  = 1'b1;
      chk_en = 1;
      wait_active(1, 16, "restart_attack");
      cyc(20);
      note = '0;
      cyc(24);

      // Randomized note/octave traffic.
      for (int s = 0; s < 30; s++) begin
         for (int v = 0; v < NV; v++) begin
            note[3*v +: 3]   = ($urandom_range(0, 9) < 3) ? 3'd0 : 3'($urandom_range(1, 7));
            octave[3*v +: 3] = 3'($urandom_range(4, 7));
         end
         cyc($urandom_range(20, 500));
      end

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
